// File: rtl/nrx_video_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nrx_video_pkg : timing constants and offset helpers for nrx_video_timing. Rev 1.0
// ----------------------------------------------------------------------------
package nrx_video_pkg;

  localparam logic [8:0] H_ACTIVE_END = 9'd288;
  localparam logic [8:0] H_JUMP_FROM  = 9'd342;
  localparam logic [8:0] H_JUMP_TO    = 9'd471;
  localparam logic [8:0] H_WRAP       = 9'd511;
  localparam logic [8:0] HS_START     = 9'd311;
  localparam logic [8:0] HS_WIDTH     = 9'd24;
  localparam logic [8:0] V_ACTIVE_END = 9'd223;
  localparam logic [8:0] V_JUMP_FROM  = 9'd233;
  localparam logic [8:0] V_JUMP_TO    = 9'd483;
  localparam logic [8:0] V_WRAP       = 9'd511;
  localparam logic [8:0] VS_START     = 9'd227;
  localparam logic [8:0] VS_WIDTH     = 9'd3;

  typedef struct packed {
    logic [3:0] h;
    logic [2:0] v;
  } sync_ofs_t;

  // Offsets -4 and -3 would pull vsync into the active area's neighbour lines.
  function automatic logic [2:0] clamp_vofs(input logic [2:0] v);
    return ((v == 3'b100) || (v == 3'b101)) ? 3'b110 : v;
  endfunction

  function automatic logic [8:0] add_hofs(input logic [8:0] base, input logic [3:0] ofs);
    return base + {{5{ofs[3]}}, ofs};
  endfunction

  function automatic logic [8:0] add_vofs(input logic [8:0] base, input logic [2:0] ofs);
    return base + {{6{ofs[2]}}, ofs};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nrx_ce_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nrx_ce_div : clock divider producing a one-cycle pixel enable. Rev 1.0
// ----------------------------------------------------------------------------
module nrx_ce_div
  import nrx_video_pkg::*;
#(
  parameter int CE_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic ce_o
);

  localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    ce_o  = (div_q == DIV_LAST);
    div_d = ce_o ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nrx_video_timing.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nrx_video_timing : New Rally-X counters, blanking, syncs and blanked RGB. Rev 1.0
// ----------------------------------------------------------------------------
module nrx_video_timing
  import nrx_video_pkg::*;
#(
  parameter int CE_DIV = 4,
  parameter int RGB_W  = 12
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [3:0]       h_ofs,
  input  logic [2:0]       v_ofs,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             ce_pix,
  output logic [8:0]       hpos,
  output logic [8:0]       vpos,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic [RGB_W-1:0] rgb_out,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  logic             ce;
  logic [8:0]       hpos_q, hpos_d;
  logic [8:0]       vpos_q, vpos_d;
  logic             hblank_q, vblank_q;
  logic             hsync_n_q, vsync_n_q;
  logic [RGB_W-1:0] rgb_q;
  logic             frame_start_q;
  logic [7:0]       frame_cnt_q;
  sync_ofs_t        ofs_q;
  logic             line_end, frame_end;
  logic [8:0]       hs_on, hs_off, vs_on, vs_off;

  nrx_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .ce_o   (ce)
  );

  always_comb begin
    line_end  = (hpos_q == H_WRAP);
    frame_end = line_end && (vpos_q == V_WRAP);
    hpos_d    = (hpos_q == H_JUMP_FROM) ? H_JUMP_TO : hpos_q + 9'd1;
    vpos_d    = vpos_q;
    if (line_end) begin
      vpos_d = (vpos_q == V_JUMP_FROM) ? V_JUMP_TO : vpos_q + 9'd1;
    end
    hs_on  = add_hofs(HS_START, ofs_q.h);
    hs_off = hs_on + HS_WIDTH;
    vs_on  = add_vofs(VS_START, ofs_q.v);
    vs_off = vs_on + VS_WIDTH;
  end

  // Syncs compare against the next counter value so they toggle together with hpos/vpos.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      ofs_q         <= '0;
    end else begin
      frame_start_q <= 1'b0;
      if (ce) begin
        hpos_q <= hpos_d;
        vpos_q <= vpos_d;
        rgb_q  <= (hblank_q || vblank_q) ? '0 : rgb_in;

        if (hpos_q == H_ACTIVE_END) begin
          hblank_q <= 1'b1;
        end else if (line_end) begin
          hblank_q <= 1'b0;
        end

        if (hpos_d == hs_on) begin
          hsync_n_q <= 1'b0;
        end else if (hpos_d == hs_off) begin
          hsync_n_q <= 1'b1;
        end

        if (line_end) begin
          if (vpos_q == V_ACTIVE_END) begin
            vblank_q <= 1'b1;
          end else if (frame_end) begin
            vblank_q <= 1'b0;
          end
          if (vpos_d == vs_on) begin
            vsync_n_q <= 1'b0;
          end else if (vpos_d == vs_off) begin
            vsync_n_q <= 1'b1;
          end
        end

        if (frame_end) begin
          ofs_q.h       <= h_ofs;
          ofs_q.v       <= clamp_vofs(v_ofs);
          frame_start_q <= 1'b1;
          frame_cnt_q   <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  assign ce_pix      = ce;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign rgb_out     = rgb_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nrx_video_timing.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nrx_video_timing : self-checking bench for nrx_video_timing. Rev 1.0
// ----------------------------------------------------------------------------
module tb_nrx_video_timing;

  localparam int RGB_W = 12;

  typedef struct packed {
    logic [3:0] h;
    logic [2:0] v;
    logic [8:0] hs_lo;
    logic [8:0] hs_hi;
    logic [8:0] vs_lo;
    logic [8:0] vs_hi;
  } vec_t;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic [3:0]       h_ofs;
  logic [2:0]       v_ofs;
  logic [RGB_W-1:0] rgb_in;
  logic             ce_pix;
  logic [8:0]       hpos, vpos;
  logic             hblank, vblank, hsync_n, vsync_n;
  logic [RGB_W-1:0] rgb_out;
  logic             frame_start;
  logic [7:0]       frame_cnt;

  int checks = 0;
  int errors = 0;

  vec_t             tbl [4];
  vec_t             cur, pend;
  logic [8:0]       m_h, m_v, jv;
  logic [7:0]       m_fc;
  logic             first_line, first_frame, first_px;
  logic             e_hb, e_vb, e_hs, e_vs, e_fs;
  logic [RGB_W-1:0] e_rgb, rgb_cur;

  nrx_video_timing #(.CE_DIV(4), .RGB_W(RGB_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .h_ofs       (h_ofs),
    .v_ofs       (v_ofs),
    .rgb_in      (rgb_in),
    .ce_pix      (ce_pix),
    .hpos        (hpos),
    .vpos        (vpos),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .rgb_out     (rgb_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_reset();
    m_h = '0; m_v = '0; m_fc = '0;
    first_line = 1'b1; first_frame = 1'b1; first_px = 1'b1;
    e_hb = 1'b1; e_vb = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    e_rgb = '0;
    cur = tbl[0];
  endtask

  task automatic set_ofs(input vec_t r);
    h_ofs = r.h;
    v_ofs = r.v;
    pend  = r;
  endtask

  task automatic check_rst(input string name);
    logic [43:0] got, want;
    got  = {ce_pix, hpos, vpos, hblank, vblank, hsync_n, vsync_n, rgb_out, frame_start, frame_cnt};
    want = {1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 8'd0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s h=%0d v=%0d got %b want %b", name, m_h, m_v, got, want);
    end
  endtask

  // One pixel: wait for the enabling edge, advance the reference model, compare.
  task automatic px();
    int   n;
    logic prev_blank, wrap;
    logic [52:0] got, want;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
      if (n == 2) check_bit("fs_width", frame_start, 1'b0);
    end while (ce_pix !== 1'b1 && n < 8);
    checks++;
    if (n != (first_px ? 3 : 4)) begin
      errors++;
      $display("FAIL ce_period h=%0d v=%0d got %0d clocks want %0d", m_h, m_v, n, first_px ? 3 : 4);
    end
    first_px = 1'b0;
    @(posedge clk_sys);
    #1;
    prev_blank = e_hb | e_vb;
    e_rgb = prev_blank ? '0 : rgb_cur;
    wrap  = (m_h == 9'd511) && (m_v == 9'd511);
    if (m_h == 9'd511) begin
      first_line = 1'b0;
      if (m_v == 9'd233)      m_v = 9'd483;
      else if (m_v == 9'd511) m_v = 9'd0;
      else                    m_v = m_v + 9'd1;
    end
    if (m_h == 9'd342)      m_h = 9'd471;
    else if (m_h == 9'd511) m_h = 9'd0;
    else                    m_h = m_h + 9'd1;
    e_fs = wrap;
    if (wrap) begin
      first_frame = 1'b0;
      m_fc = m_fc + 8'd1;
      cur  = pend;
    end
    e_hb = first_line || (m_h > 9'd288);
    e_vb = first_frame || (m_v >= 9'd224);
    e_hs = !((m_h >= cur.hs_lo) && (m_h <= cur.hs_hi));
    e_vs = !((m_v >= cur.vs_lo) && (m_v <= cur.vs_hi));
    got  = {hpos, vpos, hblank, vblank, hsync_n, vsync_n, frame_start, ce_pix, frame_cnt, rgb_out};
    want = {m_h, m_v, e_hb, e_vb, e_hs, e_vs, e_fs, 1'b0, m_fc, e_rgb};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pix got hpos=%0d vpos=%0d hb=%b vb=%b hs=%b vs=%b fs=%b ce=%b fc=%0d rgb=%h want hpos=%0d vpos=%0d hb=%b vb=%b hs=%b vs=%b fs=%b ce=0 fc=%0d rgb=%h",
               hpos, vpos, hblank, vblank, hsync_n, vsync_n, frame_start, ce_pix, frame_cnt, rgb_out,
               m_h, m_v, e_hb, e_vb, e_hs, e_vs, e_fs, m_fc, e_rgb);
    end
    rgb_cur = 12'hABC ^ {3'b000, m_h};
    rgb_in  = rgb_cur;
  endtask

  task automatic run_to_h(input logic [8:0] target);
    int k;
    k = 0;
    do begin
      px();
      k++;
    end while (m_h != target && k < 600);
  endtask

  // Skip idle lines: only used where blank/sync state is identical at both line numbers.
  task automatic jump_v(input logic [8:0] v);
    jv = v;
    force dut.vpos_q = jv;
    #1;
    release dut.vpos_q;
    m_v = v;
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{h: 4'd0, v: 3'd0,      hs_lo: 9'd311, hs_hi: 9'd334, vs_lo: 9'd227, vs_hi: 9'd229};
    tbl[1] = '{h: 4'd7, v: 3'd3,      hs_lo: 9'd318, hs_hi: 9'd341, vs_lo: 9'd230, vs_hi: 9'd232};
    tbl[2] = '{h: 4'h8, v: 3'b100,    hs_lo: 9'd303, hs_hi: 9'd326, vs_lo: 9'd225, vs_hi: 9'd227};
    tbl[3] = '{h: 4'd5, v: 3'b101,    hs_lo: 9'd316, hs_hi: 9'd339, vs_lo: 9'd225, vs_hi: 9'd227};

    reset_n = 1'b0;
    h_ofs   = 4'd5;
    v_ofs   = 3'd3;
    rgb_cur = 12'hABC;
    rgb_in  = rgb_cur;
    pend    = tbl[0];
    model_reset();
    repeat (3) @(negedge clk_sys);
    check_rst("reset_state");
    reset_n = 1'b1;

    // First frame: latched offsets are zero regardless of inputs, whole frame blanked.
    run_to_h(9'd480);

    for (int i = 0; i < 3; i++) begin
      set_ofs(tbl[i]);
      jump_v(9'd511);
      run_to_h(9'd0);
      set_ofs(tbl[i+1]);
      run_to_h(9'd480);
      jump_v(9'd223);
      for (int k = 0; k < 12 && m_v != 9'd233; k++) run_to_h(9'd480);
    end

    // Frame counter wrap and clamp of -3 on the next frame.
    set_ofs(tbl[3]);
    jv = 9'd0;
    force dut.frame_cnt_q = 8'hFF;
    #1;
    release dut.frame_cnt_q;
    m_fc = 8'hFF;
    jump_v(9'd511);
    run_to_h(9'd0);
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap got %0d want 0", frame_cnt);
    end

    // Reset in the middle of an hsync pulse on an active line.
    run_to_h(9'd10);
    jump_v(9'd50);
    run_to_h(9'd320);
    check_bit("hs_mid", hsync_n, 1'b0);
    reset_n = 1'b0;
    #2;
    check_rst("async_reset");
    repeat (3) @(negedge clk_sys);
    check_rst("reset_hold");
    model_reset();
    reset_n = 1'b1;
    run_to_h(9'd340);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
